// File: rtl/drp_reconf_seq.sv
// drp_reconf_seq: DRP master that read-modify-writes a table of PLL registers, then waits for stable lock
// Ports:
//   DCLK, RST              clock (posedge) and asynchronous active-high reset
//   i_start                begin a sequence; sampled only while idle
//   i_tbl_len              number of table entries, 0..2**TBL_AW
//   o_tbl_addr/i_tbl_data  table index out, {daddr[38:32], mask[31:16], data[15:0]} in (latency 0 or 1)
//   o_daddr/o_den/o_dwe/o_di/i_do/i_drdy  DRP master interface
//   i_locked               PLL lock status
//   o_busy/o_done/o_err    sequence in progress / one-cycle success pulse / sticky timeout flag
module drp_reconf_seq #(
  parameter int TBL_AW       = 5,
  parameter int DRDY_TIMEOUT = 64,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int LOCK_STABLE  = 4,
  parameter bit DO_AT_DRDY   = 1'b0
) (
  input  logic              DCLK,
  input  logic              RST,
  input  logic              i_start,
  input  logic [TBL_AW:0]   i_tbl_len,
  output logic [TBL_AW-1:0] o_tbl_addr,
  input  logic [38:0]       i_tbl_data,
  output logic [6:0]        o_daddr,
  output logic              o_den,
  output logic              o_dwe,
  output logic [15:0]       o_di,
  input  logic [15:0]       i_do,
  input  logic              i_drdy,
  input  logic              i_locked,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  typedef enum logic [3:0] {IDLE, FETCH0, FETCH1, RD, RD_WAIT, WR, WR_WAIT, NEXT, LOCK_WAIT, DONE_S} state_t;
  localparam int TMAX = LOCK_TIMEOUT > DRDY_TIMEOUT ? LOCK_TIMEOUT : DRDY_TIMEOUT;
  localparam int CW = $clog2(TMAX);
  localparam int LW = $clog2(LOCK_STABLE + 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [LW-1:0] STABLE = LW'(LOCK_STABLE);
  state_t            r_state;
  logic [TBL_AW-1:0] r_idx;
  logic [CW-1:0]     r_cnt;
  logic [LW-1:0]     r_lk;
  logic [15:0]       r_cap, r_mask, r_data;
  logic [15:0]       w_old;
  logic [LW-1:0]     w_lk_nxt;
  logic              w_last;
  // In first-cycle capture mode, a DRDY in the very first wait cycle must still see that cycle's DO
  assign w_old    = (DO_AT_DRDY || r_cnt == '0) ? i_do : r_cap;
  assign w_lk_nxt = i_locked ? r_lk + 1'b1 : '0;
  assign w_last   = {1'b0, r_idx} == i_tbl_len - 1'b1;
  always_ff @(posedge DCLK or posedge RST) begin
    if (RST) begin
      r_state    <= IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_lk       <= '0;
      r_cap      <= '0;
      r_mask     <= '0;
      r_data     <= '0;
      o_tbl_addr <= '0;
      o_daddr    <= '0;
      o_den      <= 1'b0;
      o_dwe      <= 1'b0;
      o_di       <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_start) begin
          o_err      <= 1'b0;
          r_idx      <= '0;
          o_tbl_addr <= '0;
          o_busy     <= i_tbl_len != '0;
          o_done     <= i_tbl_len == '0;
          r_state    <= i_tbl_len == '0 ? DONE_S : FETCH0;
        end
        FETCH0: r_state <= FETCH1;
        FETCH1: begin
          o_daddr <= i_tbl_data[38:32];
          r_mask  <= i_tbl_data[31:16];
          r_data  <= i_tbl_data[15:0];
          o_den   <= 1'b1;
          r_state <= RD;
        end
        RD: begin
          o_den   <= 1'b0;
          r_cnt   <= '0;
          r_state <= RD_WAIT;
        end
        RD_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == '0) r_cap <= i_do;
          if (i_drdy) begin
            o_di    <= (w_old & r_mask) | (r_data & ~r_mask);
            o_den   <= 1'b1;
            o_dwe   <= 1'b1;
            r_state <= WR;
          end else if (r_cnt == DRDY_LAST) begin
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        WR: begin
          o_den   <= 1'b0;
          o_dwe   <= 1'b0;
          r_cnt   <= '0;
          r_state <= WR_WAIT;
        end
        WR_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          if (i_drdy) r_state <= NEXT;
          else if (r_cnt == DRDY_LAST) begin
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        NEXT: begin
          r_cnt      <= '0;
          r_lk       <= '0;
          r_idx      <= w_last ? r_idx : r_idx + 1'b1;
          o_tbl_addr <= w_last ? r_idx : r_idx + 1'b1;
          r_state    <= w_last ? LOCK_WAIT : FETCH0;
        end
        LOCK_WAIT: begin
          r_cnt <= r_cnt + 1'b1;
          r_lk  <= w_lk_nxt;
          if (w_lk_nxt == STABLE) begin
            o_done  <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= DONE_S;
          end else if (r_cnt == LOCK_LAST) begin
            o_err   <= 1'b1;
            o_busy  <= 1'b0;
            r_state <= IDLE;
          end
        end
        DONE_S: begin
          o_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_drp_reconf_seq.sv
// tb_drp_reconf_seq: randomized bench for drp_reconf_seq with a PLL register-file model and table-level reference
module tb_drp_reconf_seq;
  logic        DCLK = 1'b0, RST = 1'b1, i_start = 1'b0, i_drdy = 1'b1, i_locked = 1'b1;
  logic [5:0]  i_tbl_len = '0;
  logic [4:0]  o_tbl_addr;
  logic [38:0] i_tbl_data = '0;
  logic [6:0]  o_daddr;
  logic        o_den, o_dwe, o_busy, o_done, o_err;
  logic [15:0] o_di, i_do = '0;
  drp_reconf_seq dut (
    .DCLK(DCLK), .RST(RST), .i_start(i_start), .i_tbl_len(i_tbl_len), .o_tbl_addr(o_tbl_addr),
    .i_tbl_data(i_tbl_data), .o_daddr(o_daddr), .o_den(o_den), .o_dwe(o_dwe), .o_di(o_di),
    .i_do(i_do), .i_drdy(i_drdy), .i_locked(i_locked), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );
  always #5 DCLK = ~DCLK;
  logic [38:0] tbl [32];
  logic [15:0] regs [128];
  logic [15:0] refr [128];
  always @(posedge DCLK) i_tbl_data <= tbl[o_tbl_addr];
  typedef struct {int c; bit we; logic [6:0] a; logic [15:0] d;} tx_t;
  tx_t txq[$];
  int cyc = 0, den2 = 0, dcnt = 0;
  bit pden = 0;
  always @(posedge DCLK) cyc <= cyc + 1;
  always @(negedge DCLK) begin
    tx_t t;
    if (o_den) begin
      t.c = cyc; t.we = o_dwe; t.a = o_daddr; t.d = o_di;
      txq.push_back(t);
    end
    if ((o_den && pden) || (o_dwe && !o_den)) den2++;
    if (o_done) dcnt++;
    pden = o_den;
  end
  bit stuck = 0, pend = 0, wc = 0;
  always @(negedge DCLK) begin
    if (RST) begin
      i_drdy = 1'b1; pend = 0;
    end else if (o_den) begin
      if (o_dwe) regs[o_daddr] = o_di;
      i_drdy = 1'b0; i_do = regs[o_daddr]; pend = 1; wc = 0;
    end else if (pend && !stuck) begin
      if (wc) begin
        i_drdy = 1'b1; i_do = 16'($urandom); pend = 0;
      end else wc = 1;
    end
  end
  int total = 0, bad = 0;
  int s, ecyc, lmode = 0, d0;
  bit eerr;
  logic [6:0] pat = 7'b1111011;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic lock_drive();
    int rel = cyc - s;
    i_locked = lmode == 0 ? 1'b1 : lmode == 2 ? 1'b0 : (rel >= 9 && rel < 16) ? pat[rel-9] : rel >= 16;
  endtask
  task automatic go(int n);
    i_tbl_len = 6'(n);
    @(negedge DCLK); i_start = 1'b1;
    @(negedge DCLK); i_start = 1'b0; s = cyc;
    chk("busy_at_accept", 32'(o_busy), 32'(n != 0));
    chk("err_cleared", 32'(o_err), 0);
    lock_drive();
  endtask
  task automatic wait_end(int bound);
    ecyc = -1; eerr = 0;
    for (int i = 0; i < bound && ecyc < 0; i++) begin
      if (o_done || o_err) begin
        ecyc = cyc; eerr = o_err;
      end else begin
        @(negedge DCLK); lock_drive();
      end
    end
    chk("end_seen", 32'(ecyc >= 0), 1);
  endtask
  function automatic logic [6:0] apply(int k);
    logic [38:0] e = tbl[k];
    refr[e[38:32]] = (refr[e[38:32]] & e[31:16]) | (e[15:0] & ~e[31:16]);
    return e[38:32];
  endfunction
  task automatic check_run(int n, int off, bit e);
    tx_t r, w;
    logic [38:0] en;
    logic [6:0] a;
    chk("end_cycle", ecyc, s + off);
    chk("end_err", 32'(eerr), 32'(e));
    repeat (2) @(negedge DCLK);
    chk("tx_count", txq.size(), 2 * n);
    for (int k = 0; k < n; k++) begin
      en = tbl[k];
      a = apply(k);
      if (txq.size() == 2 * n) begin
        r = txq[2*k]; w = txq[2*k+1];
        chk("rd_cycle", r.c, s + 2 + 9 * k);
        chk("rd_we", 32'(r.we), 0);
        chk("rd_addr", 32'(r.a), 32'(en[38:32]));
        chk("wr_cycle", w.c, s + 5 + 9 * k);
        chk("wr_we", 32'(w.we), 1);
        chk("wr_addr", 32'(w.a), 32'(a));
        chk("wr_di", 32'(w.d), 32'(refr[a]));
      end
    end
    for (int k = 0; k < n; k++) begin
      en = tbl[k];
      chk("regfile", 32'(regs[en[38:32]]), 32'(refr[en[38:32]]));
    end
    chk("den_rules", den2, 0);
    chk("busy_after", 32'(o_busy), 0);
    chk("err_flag", 32'(o_err), 32'(e));
    chk("done_pulses", dcnt - d0, e ? 0 : 1);
  endtask
  task automatic run(int n, int off, bit e);
    txq.delete(); d0 = dcnt;
    go(n);
    wait_end(9 * n + 4200);
    check_run(n, off, e);
  endtask
  task automatic fill(int n);
    for (int k = 0; k < n; k++) tbl[k] = {7'($urandom), 16'($urandom), 16'($urandom)};
  endtask
  initial begin
    int n;
    for (int i = 0; i < 128; i++) begin
      regs[i] = 16'($urandom); refr[i] = regs[i];
    end
    regs[8] = 16'h1041; refr[8] = 16'h1041;
    for (int k = 0; k < 32; k++) tbl[k] = '0;
    repeat (3) @(negedge DCLK);
    RST = 1'b0;
    @(negedge DCLK);
    chk("rst_den", 32'(o_den), 0);
    chk("rst_dwe", 32'(o_dwe), 0);
    chk("rst_daddr", 32'(o_daddr), 0);
    chk("rst_di", 32'(o_di), 0);
    chk("rst_tbl_addr", 32'(o_tbl_addr), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_done", 32'(o_done), 0);
    chk("rst_err", 32'(o_err), 0);
    tbl[0] = {7'h08, 16'hF000, 16'h0082};
    run(1, 13, 0);
    if (txq.size() > 1) chk("rmw_di", 32'(txq[1].d), 32'h1082);
    chk("rmw_reg", 32'(regs[8]), 32'h1082);
    fill(3);
    tbl[0][38:32] = 7'h14; tbl[1][38:32] = 7'h15; tbl[2][38:32] = 7'h16;
    run(3, 31, 0);
    for (int r = 0; r < 4; r++) begin
      n = $urandom_range(1, 8);
      fill(n);
      run(n, 9 * n + 4, 0);
    end
    fill(32);
    run(32, 9 * 32 + 4, 0);
    run(0, 0, 0);
    fill(1);
    stuck = 1; txq.delete(); d0 = dcnt;
    go(1);
    wait_end(200);
    chk("drdy_to_cycle", ecyc, s + 67);
    chk("drdy_to_err", 32'(eerr), 1);
    chk("drdy_to_busy", 32'(o_busy), 0);
    repeat (20) @(negedge DCLK);
    chk("no_den_after_err", txq.size(), 1);
    chk("err_sticky", 32'(o_err), 1);
    chk("no_done_on_err", dcnt - d0, 0);
    stuck = 0;
    repeat (4) @(negedge DCLK);
    fill(2);
    run(2, 22, 0);
    fill(3);
    txq.delete();
    go(3);
    repeat (15) @(negedge DCLK);
    chk("pre_rst_busy", 32'(o_busy), 1);
    RST = 1'b1;
    #1;
    chk("async_den", 32'(o_den), 0);
    chk("async_busy", 32'(o_busy), 0);
    chk("async_daddr", 32'(o_daddr), 0);
    chk("abort_tx", txq.size(), 4);
    void'(apply(0));
    void'(apply(1));
    @(negedge DCLK); RST = 1'b0;
    repeat (3) @(negedge DCLK);
    chk("no_den_post_rst", txq.size(), 4);
    run(3, 31, 0);
    fill(1);
    lmode = 1; i_locked = 1'b0;
    run(1, 16, 0);
    fill(1);
    lmode = 2; i_locked = 1'b0;
    run(1, 9 + 4096, 1);
    lmode = 0; i_locked = 1'b1;
    fill(2);
    run(2, 22, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
